// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
//   Shared definitions for the single-port RAM command path: the two-bit
//   opcodes carried in ram_din[top:top-1] and the sequencer state encoding.
package ram_ctrl_pkg;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;  // latch write address
   localparam logic [1:0] OP_WR_DATA = 2'b01;  // write data to latched write address
   localparam logic [1:0] OP_RD_ADDR = 2'b10;  // latch read address
   localparam logic [1:0] OP_RD_DATA = 2'b11;  // read from latched read address

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter. The grant is combinational from req and the stored
//   last_grant pointer; the search starts one past last_grant. The pointer
//   moves only when the consumer accepts (advance), and resets to NUM_REQ-1
//   so requester 0 has first priority out of reset.
// Ports
//   clk, rst_n : clock, synchronous active-low reset
//   req        : per-requester request
//   advance    : the current grant is being accepted this cycle
//   grant      : one-hot grant (all zero when no request)
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] cand;
   logic             found;

   // Walk the requesters starting after last_grant; first set request wins.
   always_comb begin
      grant     = '0;
      grant_idx = last_grant;
      cand      = '0;
      found     = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= IDX_W'(NUM_REQ - 1);
      end else if (advance && found) begin
         last_grant <= grant_idx;
      end
   end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter
//   Shares one single-port RAM between NUM_REQ requesters. Each accepted
//   transaction is issued as an atomic two-command pair (address latch, then
//   data write or read), so no other requester can slip a command between
//   them. Read data returns as a one-cycle per-requester pulse; a read whose
//   data never arrives is answered with rsp_err after RD_TIMEOUT WAIT cycles.
// Ports
//   clk, rst_n    : clock, synchronous active-low reset
//   req_valid     : per-requester transaction request
//   req_ready     : one-hot accept (combinational, only in IDLE)
//   req_wr        : per-requester 1 = write, 0 = read
//   req_addr      : packed addresses, requester i at [i*ADDR_SIZE +: ADDR_SIZE]
//   req_wdata     : packed write data, same packing
//   rsp_valid     : one-hot one-cycle read-response pulse
//   rsp_data      : read data (0 on timeout)
//   rsp_err       : read timed out, qualifies rsp_valid
//   ram_din       : RAM command {opcode, payload}
//   ram_rx_valid  : RAM command strobe
//   ram_dout      : RAM read data
//   ram_tx_valid  : RAM read-data strobe
module ram_cmd_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_SIZE  = 8,
   parameter int RD_TIMEOUT = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_wr,
   input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
   input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [ADDR_SIZE-1:0]           rsp_data,
   output logic                           rsp_err,
   output logic [ADDR_SIZE+1:0]           ram_din,
   output logic                           ram_rx_valid,
   input  logic [ADDR_SIZE-1:0]           ram_dout,
   input  logic                           ram_tx_valid
);

   localparam int TW = $clog2(RD_TIMEOUT + 1);

   state_t                state, state_nxt;
   logic [NUM_REQ-1:0]    grant;
   logic                  accept;
   logic                  sel_wr;
   logic [ADDR_SIZE-1:0]  sel_addr, sel_wdata;

   // Captured transaction; payload registers need no reset because they are
   // only consumed after an accept has loaded them.
   logic [NUM_REQ-1:0]    owner_q;
   logic                  wr_q;
   logic [ADDR_SIZE-1:0]  addr_q, wdata_q;
   logic [TW-1:0]         timer;

   logic                  rx_valid_nxt;
   logic [ADDR_SIZE+1:0]  din_nxt;
   logic                  rsp_fire;
   logic [ADDR_SIZE-1:0]  rsp_data_nxt;
   logic                  rsp_err_nxt;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .advance (accept),
      .grant   (grant)
   );

   // Gated by rst_n so nothing is accepted while reset is being applied.
   assign req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
   assign accept    = |req_ready;

   // Field mux for the granted requester.
   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_wr    = req_wr[i];
            sel_addr  = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
            sel_wdata = req_wdata[i*ADDR_SIZE +: ADDR_SIZE];
         end
      end
   end

   // State register, timer, capture and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         timer        <= '0;
         ram_rx_valid <= 1'b0;
         ram_din      <= '0;
         rsp_valid    <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
      end else begin
         state        <= state_nxt;
         ram_rx_valid <= rx_valid_nxt;
         ram_din      <= din_nxt;
         rsp_valid    <= rsp_fire ? owner_q : '0;
         if (rsp_fire) begin
            rsp_data <= rsp_data_nxt;
            rsp_err  <= rsp_err_nxt;
         end
         // Timer holds the 1-based index of the current WAIT cycle.
         if (state == ST_DATA)      timer <= TW'(1);
         else if (state == ST_WAIT) timer <= timer + TW'(1);
         else                       timer <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         owner_q <= grant;
         wr_q    <= sel_wr;
         addr_q  <= sel_addr;
         wdata_q <= sel_wdata;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_ADDR;
         ST_ADDR: state_nxt = ST_DATA;
         ST_DATA: state_nxt = wr_q ? ST_IDLE : ST_WAIT;
         ST_WAIT: if (ram_tx_valid || timer == TW'(RD_TIMEOUT)) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: values loaded into the output registers at the next edge,
   // so each command appears in the cycle whose state names it.
   always_comb begin
      rx_valid_nxt = 1'b0;
      din_nxt      = '0;
      rsp_fire     = 1'b0;
      rsp_data_nxt = '0;
      rsp_err_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               rx_valid_nxt = 1'b1;
               din_nxt      = {sel_wr ? OP_WR_ADDR : OP_RD_ADDR, sel_addr};
            end
         end
         ST_ADDR: begin
            rx_valid_nxt = 1'b1;
            din_nxt      = wr_q ? {OP_WR_DATA, wdata_q} : {OP_RD_DATA, {ADDR_SIZE{1'b0}}};
         end
         ST_WAIT: begin
            if (ram_tx_valid) begin
               rsp_fire     = 1'b1;
               rsp_data_nxt = ram_dout;
            end else if (timer == TW'(RD_TIMEOUT)) begin
               rsp_fire    = 1'b1;
               rsp_err_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// tb_ram_cmd_arbiter
//   Directed bench for ram_cmd_arbiter (NUM_REQ=2, ADDR_SIZE=8, RD_TIMEOUT=4)
//   with a behavioural single-port RAM that decodes the opcode commands.
module tb_ram_cmd_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready, req_wr;
   logic [15:0] req_addr, req_wdata;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic [9:0]  ram_din;
   logic        ram_rx_valid;
   logic [7:0]  ram_dout;
   logic        ram_tx_valid;

   // RAM model state
   logic [7:0]  mem [256];
   logic [7:0]  wa, ra;
   logic        mtx;
   logic        ram_en;
   logic        stray;

   int vectors;
   int miscompares;

   logic [9:0] exp_acmd [2];
   logic [9:0] exp_dcmd [2];

   ram_cmd_arbiter #(.NUM_REQ(2), .ADDR_SIZE(8), .RD_TIMEOUT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wr       (req_wr),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end, expected finish");
      $fatal(1, "watchdog");
   end

   // Behavioural RAM: registers read data on the edge sampling the 11 command.
   always @(posedge clk) begin
      if (!rst_n) begin
         wa <= 8'h00; ra <= 8'h00; mtx <= 1'b0; ram_dout <= 8'h00;
      end else begin
         mtx <= 1'b0;
         if (ram_rx_valid) begin
            case (ram_din[9:8])
               2'b00: wa <= ram_din[7:0];
               2'b01: mem[wa] <= ram_din[7:0];
               2'b10: ra <= ram_din[7:0];
               default: if (ram_en) begin mtx <= 1'b1; ram_dout <= mem[ra]; end
            endcase
         end
      end
   end

   assign ram_tx_valid = mtx | stray;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst_n = 1'b0; req_valid = 2'b11; req_wr = 2'b00;
      req_addr = 16'h0; req_wdata = 16'h0; ram_en = 1'b1; stray = 1'b0;
      exp_acmd[0] = 10'h030; exp_acmd[1] = 10'h041;
      exp_dcmd[0] = 10'h15A; exp_dcmd[1] = 10'h16B;

      // Reset state (requests present but must not be accepted)
      tick(); tick(); tick(); #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rxv", 32'(ram_rx_valid), 32'h0);
      chk("rst_din", 32'(ram_din), 32'h0);
      chk("rst_rspv", 32'(rsp_valid), 32'h0);
      chk("rst_rspd", 32'(rsp_data), 32'h0);
      chk("rst_err", 32'(rsp_err), 32'h0);
      req_valid = 2'b00;
      rst_n = 1'b1;

      // Requester 0 writes 0xA5 to 0x12
      tick();
      req_valid = 2'b01; req_wr = 2'b01; req_addr = 16'h0012; req_wdata = 16'h00A5;
      #1 chk("wr_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = 2'b00; #1;
      chk("wr_acmd", 32'(ram_din), 32'h012);
      chk("wr_arxv", 32'(ram_rx_valid), 32'h1);
      tick(); #1;
      chk("wr_dcmd", 32'(ram_din), 32'h1A5);
      chk("wr_drxv", 32'(ram_rx_valid), 32'h1);
      // T+3: IDLE, requester 1 read of 0x12 accepted immediately
      tick();
      req_valid = 2'b10; req_wr = 2'b00; req_addr = 16'h1200;
      #1;
      chk("wr_idle_rxv", 32'(ram_rx_valid), 32'h0);
      chk("rd_ready", 32'(req_ready), 32'h2);
      tick(); req_valid = 2'b00; #1;
      chk("rd_acmd", 32'(ram_din), 32'h212);
      tick(); #1;
      chk("rd_dcmd", 32'(ram_din), 32'h300);
      chk("rd_drxv", 32'(ram_rx_valid), 32'h1);
      tick(); #1;
      chk("rd_wait_rxv", 32'(ram_rx_valid), 32'h0);
      chk("rd_wait_rspv", 32'(rsp_valid), 32'h0);
      tick(); #1;
      chk("rd_rspv", 32'(rsp_valid), 32'h2);
      chk("rd_rspd", 32'(rsp_data), 32'hA5);
      chk("rd_err", 32'(rsp_err), 32'h0);
      tick(); #1;
      chk("rd_pulse", 32'(rsp_valid), 32'h0);

      // Both requesters hold writes continuously from reset release
      rst_n = 1'b0;
      tick(); tick();
      req_valid = 2'b11; req_wr = 2'b11; req_addr = 16'h4130; req_wdata = 16'h6B5A;
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_ready%0d", i), 32'(req_ready), 32'(2'b01 << (i % 2)));
         tick(); #1;
         chk($sformatf("rr_acmd%0d", i), 32'(ram_din), 32'(exp_acmd[i % 2]));
         tick(); #1;
         chk($sformatf("rr_dcmd%0d", i), 32'(ram_din), 32'(exp_dcmd[i % 2]));
         chk($sformatf("rr_drxv%0d", i), 32'(ram_rx_valid), 32'h1);
         tick(); #1;
      end
      req_valid = 2'b00;

      // Read timeout: requester 0 reads 0x30, RAM silent
      tick();
      ram_en = 1'b0; req_valid = 2'b01; req_wr = 2'b00; req_addr = 16'h3030;
      #1 chk("to_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = 2'b00; #1;
      chk("to_acmd", 32'(ram_din), 32'h230);
      tick(); #1;
      chk("to_dcmd", 32'(ram_din), 32'h300);
      for (int j = 0; j < 4; j++) begin
         tick(); #1;
         chk($sformatf("to_wait%0d", j), 32'(rsp_valid), 32'h0);
      end
      tick(); #1;
      chk("to_rspv", 32'(rsp_valid), 32'h1);
      chk("to_err", 32'(rsp_err), 32'h1);
      chk("to_rspd", 32'(rsp_data), 32'h0);
      ram_en = 1'b1; req_valid = 2'b10;
      #1 chk("to_next_ready", 32'(req_ready), 32'h2);
      tick(); req_valid = 2'b00; #1;
      chk("to_next_acmd", 32'(ram_din), 32'h230);
      tick(); #1;
      chk("to_next_dcmd", 32'(ram_din), 32'h300);
      tick(); tick(); #1;
      chk("to_next_rspv", 32'(rsp_valid), 32'h2);
      chk("to_next_rspd", 32'(rsp_data), 32'h5A);
      chk("to_next_err", 32'(rsp_err), 32'h0);

      // Reset in the DATA cycle of a write
      tick();
      req_valid = 2'b01; req_wr = 2'b01; req_addr = 16'h3055; req_wdata = 16'h0077;
      #1 chk("rd_ab_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = 2'b00; #1;
      chk("ab_acmd", 32'(ram_din), 32'h055);
      tick(); #1;
      chk("ab_dcmd", 32'(ram_din), 32'h177);
      rst_n = 1'b0;
      tick(); req_valid = 2'b11; #1;
      chk("ab_rxv", 32'(ram_rx_valid), 32'h0);
      chk("ab_din", 32'(ram_din), 32'h0);
      chk("ab_rspv", 32'(rsp_valid), 32'h0);
      chk("ab_ready_rst", 32'(req_ready), 32'h0);
      rst_n = 1'b1;
      #1 chk("ab_first_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = 2'b00; #1;
      chk("ab_first_acmd", 32'(ram_din), 32'h055);
      tick(); tick(); #1;
      chk("ab_done_rxv", 32'(ram_rx_valid), 32'h0);

      // Stray ram_tx_valid in IDLE
      stray = 1'b1;
      tick(); stray = 1'b0; #1;
      chk("stray_rspv", 32'(rsp_valid), 32'h0);
      chk("stray_rxv", 32'(ram_rx_valid), 32'h0);

      // Requester 1 raises then drops req_valid while requester 0 reads 0x55
      req_valid = 2'b01; req_wr = 2'b00;
      #1 chk("dr_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = 2'b10; #1;
      chk("dr_busy_ready", 32'(req_ready), 32'h0);
      chk("dr_acmd", 32'(ram_din), 32'h255);
      tick(); #1;
      chk("dr_dcmd", 32'(ram_din), 32'h300);
      req_valid = 2'b00;
      tick(); tick(); #1;
      chk("dr_rspv", 32'(rsp_valid), 32'h1);
      chk("dr_rspd", 32'(rsp_data), 32'h77);
      tick(); #1;
      chk("dr_idle_rxv0", 32'(ram_rx_valid), 32'h0);
      tick(); #1;
      chk("dr_idle_rxv1", 32'(ram_rx_valid), 32'h0);
      chk("dr_idle_rspv", 32'(rsp_valid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
